// File: rtl/psg_stereo_dac.sv
// rtl/psg_stereo_dac.sv - three-channel PSG stereo mixer with mute ramp and sigma-delta DACs
module psg_stereo_dac #(
  parameter int IN_W   = 12,
  parameter int MIX_W  = IN_W + 2,
  parameter int RAMP_W = 4
) (
  input  logic             clk_i,
  input  logic             res_n_i,
  input  logic             sample_en,
  input  logic [IN_W-1:0]  ch_a,
  input  logic [IN_W-1:0]  ch_b,
  input  logic [IN_W-1:0]  ch_c,
  input  logic [1:0]       mode,
  input  logic             mute,
  output logic [MIX_W-1:0] pcm_l_o,
  output logic [MIX_W-1:0] pcm_r_o,
  output logic             dac_l_o,
  output logic             dac_r_o,
  output logic             muted_o
);

  // att spans 0..MIX_W inclusive; MIX_W means every bit is shifted out.
  localparam int ATT_W = $clog2(MIX_W + 1);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MIX_W);

  localparam logic [1:0] MODE_ABC = 2'b01;
  localparam logic [1:0] MODE_ACB = 2'b10;

  logic [MIX_W-1:0]  w_a, w_b, w_c;
  logic [MIX_W-1:0]  w_mix_l, w_mix_r;
  logic [ATT_W-1:0]  w_att_next;
  logic [MIX_W:0]    w_acc_l_next, w_acc_r_next;

  logic [MIX_W-1:0]  r_pcm_l, r_pcm_r;
  logic [RAMP_W-1:0] r_ramp;
  logic [ATT_W-1:0]  r_att;
  logic              r_muted;
  logic [MIX_W:0]    r_acc_l, r_acc_r;
  logic              r_dac_l, r_dac_r;

  assign w_a = MIX_W'(ch_a);
  assign w_b = MIX_W'(ch_b);
  assign w_c = MIX_W'(ch_c);

  // Stereo mix: the channel panned to a side counts double, the centre one once.
  always_comb begin
    w_mix_l = w_a + w_b + w_c;
    w_mix_r = w_a + w_b + w_c;
    case (mode)
      MODE_ABC: begin
        w_mix_l = (w_a << 1) + w_b;
        w_mix_r = (w_c << 1) + w_b;
      end
      MODE_ACB: begin
        w_mix_l = (w_a << 1) + w_c;
        w_mix_r = (w_b << 1) + w_c;
      end
      default: ;
    endcase
  end

  // Next attenuation: one step toward the mute target at the end of each ramp period.
  always_comb begin
    w_att_next = r_att;
    if (&r_ramp) begin
      if (mute && (r_att < ATT_MAX))
        w_att_next = r_att + 1'b1;
      else if (!mute && (r_att != '0))
        w_att_next = r_att - 1'b1;
    end
  end

  // Sample path: latch attenuated PCM with the pre-update att, then advance the ramp.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_pcm_l <= '0;
      r_pcm_r <= '0;
      r_ramp  <= '0;
      r_att   <= ATT_MAX;
      r_muted <= 1'b1;
    end else if (sample_en) begin
      r_pcm_l <= w_mix_l >> r_att;
      r_pcm_r <= w_mix_r >> r_att;
      r_ramp  <= r_ramp + 1'b1;
      r_att   <= w_att_next;
      r_muted <= (w_att_next == ATT_MAX);
    end
  end

  // First-order modulators: the carry out of the MIX_W-bit accumulator is the bitstream.
  assign w_acc_l_next = {1'b0, r_acc_l[MIX_W-1:0]} + {1'b0, r_pcm_l};
  assign w_acc_r_next = {1'b0, r_acc_r[MIX_W-1:0]} + {1'b0, r_pcm_r};

  // Sigma-delta accumulators and registered bitstream outputs, updated every clock.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_dac_l <= 1'b0;
      r_dac_r <= 1'b0;
    end else begin
      r_acc_l <= w_acc_l_next;
      r_acc_r <= w_acc_r_next;
      r_dac_l <= w_acc_l_next[MIX_W];
      r_dac_r <= w_acc_r_next[MIX_W];
    end
  end

  assign pcm_l_o = r_pcm_l;
  assign pcm_r_o = r_pcm_r;
  assign dac_l_o = r_dac_l;
  assign dac_r_o = r_dac_r;
  assign muted_o = r_muted;

endmodule

// File: tb/tb_psg_stereo_dac.sv
// tb/tb_psg_stereo_dac.sv - directed self-checking bench for psg_stereo_dac
module tb_psg_stereo_dac;

  logic        clk_i = 1'b0;
  logic        res_n_i;
  logic        sample_en;
  logic [11:0] ch_a, ch_b, ch_c;
  logic [1:0]  mode;
  logic        mute;
  logic [13:0] pcm_l_o, pcm_r_o;
  logic        dac_l_o, dac_r_o;
  logic        muted_o;

  int n_checks = 0;
  int n_err    = 0;
  int n_samples = 0;
  int ones_l, ones_r;

  psg_stereo_dac dut (
    .clk_i     (clk_i),
    .res_n_i   (res_n_i),
    .sample_en (sample_en),
    .ch_a      (ch_a),
    .ch_b      (ch_b),
    .ch_c      (ch_c),
    .mode      (mode),
    .mute      (mute),
    .pcm_l_o   (pcm_l_o),
    .pcm_r_o   (pcm_r_o),
    .dac_l_o   (dac_l_o),
    .dac_r_o   (dac_r_o),
    .muted_o   (muted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One strobe followed by three idle clocks.
  task automatic sample();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    n_samples++;
    repeat (3) tick();
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) sample();
  endtask

  initial begin
    res_n_i = 1'b0; sample_en = 1'b0; mute = 1'b0; mode = 2'b01;
    ch_a = 12'h100; ch_b = 12'h010; ch_c = 12'h001;
    repeat (3) tick();
    check("rst_pcm_l", 32'(pcm_l_o), 32'h0);
    check("rst_pcm_r", 32'(pcm_r_o), 32'h0);
    check("rst_dac",   32'({dac_l_o, dac_r_o}), 32'h0);
    check("rst_muted", 32'(muted_o), 32'h1);
    res_n_i = 1'b1;
    tick();

    // Power-up fade-in: att 14 -> 13 on the 16th strobe.
    samples(15);
    check("fadein_muted_15", 32'(muted_o), 32'h1);
    check("fadein_pcm_15", 32'(pcm_l_o), 32'h0);
    sample();
    check("fadein_muted_16", 32'(muted_o), 32'h0);
    // 224 strobes reach att = 0; the next strobe is the first at full level.
    samples(224 - 16);
    sample();
    check("abc_l", 32'(pcm_l_o), 32'h210);
    check("abc_r", 32'(pcm_r_o), 32'h012);

    // Mode change between strobes holds pcm until the next strobe.
    mode = 2'b10;
    tick();
    check("acb_hold_l", 32'(pcm_l_o), 32'h210);
    sample();
    check("acb_l", 32'(pcm_l_o), 32'h201);
    check("acb_r", 32'(pcm_r_o), 32'h021);
    mode = 2'b00;
    sample();
    check("mono_l", 32'(pcm_l_o), 32'h111);
    check("mono_r", 32'(pcm_r_o), 32'h111);
    mode = 2'b11;
    sample();
    check("mode11_l", 32'(pcm_l_o), 32'h111);

    // Full-scale inputs, no overflow.
    ch_a = 12'hFFF; ch_b = 12'hFFF; ch_c = 12'hFFF; mode = 2'b00;
    sample();
    check("max_mono_l", 32'(pcm_l_o), 32'h2FFD);
    check("max_mono_r", 32'(pcm_r_o), 32'h2FFD);
    mode = 2'b01;
    sample();
    check("max_abc_l", 32'(pcm_l_o), 32'h2FFD);
    check("max_abc_r", 32'(pcm_r_o), 32'h2FFD);

    // Sigma-delta density: L = 2*0x800 = 0x1000, R = 0.
    ch_a = 12'h800; ch_b = 12'h000; ch_c = 12'h000; mode = 2'b01;
    sample();
    check("sd_pcm_l", 32'(pcm_l_o), 32'h1000);
    check("sd_pcm_r", 32'(pcm_r_o), 32'h0);
    ones_l = 0; ones_r = 0;
    for (int i = 0; i < 16384; i++) begin
      tick();
      ones_l += int'(dac_l_o);
      ones_r += int'(dac_r_o);
    end
    check("sd_ones_l", 32'(ones_l), 32'd4096);
    check("sd_ones_r", 32'(ones_r), 32'd0);

    // Mute fade-out, aligned so the ramp counter is 0 before muting.
    ch_a = 12'h100; ch_b = 12'h010; ch_c = 12'h001; mode = 2'b01;
    while ((n_samples % 16) != 0) sample();
    mute = 1'b1;
    samples(16);
    sample();
    check("fade_att1", 32'(pcm_l_o), 32'h108);
    samples(15); sample();
    check("fade_att2", 32'(pcm_l_o), 32'h084);
    samples(15); sample();
    check("fade_att3", 32'(pcm_l_o), 32'h042);
    samples(15); sample();
    check("fade_att4", 32'(pcm_l_o), 32'h021);
    samples(15);
    check("fade_not_muted", 32'(muted_o), 32'h0);
    mute = 1'b0;
    sample();
    check("fade_att5", 32'(pcm_l_o), 32'h010);
    samples(15); sample();
    check("climb_att4", 32'(pcm_l_o), 32'h021);
    mute = 1'b1;
    samples(224);
    check("full_mute_flag", 32'(muted_o), 32'h1);
    check("full_mute_pcm", 32'(pcm_l_o), 32'h0);

    // Asynchronous reset mid-ramp.
    mute = 1'b0;
    samples(40);
    check("pre_rst_unmuted", 32'(muted_o), 32'h0);
    @(posedge clk_i);
    #3;
    res_n_i = 1'b0;
    #1;
    check("async_pcm", 32'({pcm_l_o, pcm_r_o}), 32'h0);
    check("async_dac", 32'({dac_l_o, dac_r_o}), 32'h0);
    check("async_muted", 32'(muted_o), 32'h1);
    tick();
    res_n_i = 1'b1;
    repeat (4) begin
      tick();
      check("post_rst_dac", 32'({dac_l_o, dac_r_o}), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
